// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - opcode/state enums, datapath select encodings and instruction field positions
package rf_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_ADDI = 4'b0100,
    OP_SUBI = 4'b0101
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2
  } state_e;

  localparam logic [1:0] DSEL_EXT = 2'b00;
  localparam logic [1:0] DSEL_Q0  = 2'b01;
  localparam logic [1:0] DSEL_G   = 2'b10;

  localparam logic BSEL_Q1  = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  localparam int INSTR_W = 10;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 3;
  localparam int RY_MSB  = 2;
  localparam int RY_LSB  = 0;

endpackage

// File: rtl/rf_ctrl_decode.sv
// rtl/rf_ctrl_decode.sv - combinational opcode classifier
module rf_ctrl_decode
  import rf_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_load,
  output logic       is_mov,
  output logic       is_alu,
  output logic       is_imm,
  output logic       is_illegal
);

  always_comb begin
    is_load    = 1'b0;
    is_mov     = 1'b0;
    is_alu     = 1'b0;
    is_imm     = 1'b0;
    is_illegal = 1'b0;
    case (opcode_e'(opcode))
      OP_LOAD: is_load = 1'b1;
      OP_MOV:  is_mov  = 1'b1;
      OP_ADD, OP_SUB: is_alu = 1'b1;
      OP_ADDI, OP_SUBI: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_controller.sv
// rtl/rf_controller.sv - register-file sequencing FSM (IDLE/T1/T2) with retired-instruction counter
module rf_controller
  import rf_ctrl_pkg::*;
(
  input  logic                 CLKb,
  input  logic                 RSTb,
  input  logic                 EXEC,
  input  logic [INSTR_W-1:0]   INSTR,
  output logic                 ENW,
  output logic [2:0]           WRA,
  output logic                 ENR0,
  output logic [2:0]           RDA0,
  output logic [2:0]           RDA1,
  output logic [1:0]           DSEL,
  output logic                 ALU_OP,
  output logic                 BSEL,
  output logic                 GIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [7:0]           ICOUNT
);

  state_e             state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] ir_nx;
  logic [2:0]         rx;
  logic [2:0]         ry;
  logic               is_load, is_mov, is_alu, is_imm, is_illegal;

  // Outputs are registered, so they are computed from the value IR will hold next cycle.
  assign ir_nx = (state == S_IDLE && EXEC) ? INSTR : ir;
  assign rx    = ir_nx[RX_MSB:RX_LSB];
  assign ry    = ir_nx[RY_MSB:RY_LSB];

  rf_ctrl_decode u_decode (
    .opcode     (ir_nx[OPC_MSB:OPC_LSB]),
    .is_load    (is_load),
    .is_mov     (is_mov),
    .is_alu     (is_alu),
    .is_imm     (is_imm),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge CLKb) begin
    ENW    <= 1'b0;
    WRA    <= '0;
    ENR0   <= 1'b0;
    RDA0   <= '0;
    RDA1   <= '0;
    DSEL   <= DSEL_EXT;
    ALU_OP <= 1'b0;
    BSEL   <= BSEL_Q1;
    GIN    <= 1'b0;
    BUSY   <= 1'b0;
    DONE   <= 1'b0;
    ERR    <= 1'b0;
    if (!RSTb) begin
      state  <= S_IDLE;
      ir     <= '0;
      ICOUNT <= '0;
    end else begin
      ir <= ir_nx;
      case (state)
        S_IDLE: if (EXEC) begin
          state <= S_T1;
          BUSY  <= 1'b1;
          if (is_load) begin
            ENW  <= 1'b1;
            WRA  <= rx;
            DSEL <= DSEL_EXT;
            DONE <= 1'b1;
          end else if (is_mov) begin
            ENR0 <= 1'b1;
            RDA0 <= ry;
            ENW  <= 1'b1;
            WRA  <= rx;
            DSEL <= DSEL_Q0;
            DONE <= 1'b1;
          end else if (is_alu) begin
            ENR0   <= 1'b1;
            RDA0   <= rx;
            RDA1   <= ry;
            BSEL   <= is_imm ? BSEL_IMM : BSEL_Q1;
            GIN    <= 1'b1;
            ALU_OP <= ir_nx[OPC_LSB];
          end else begin
            DONE <= 1'b1;
            ERR  <= 1'b1;
          end
        end
        S_T1: begin
          if (is_alu) begin
            state <= S_T2;
            BUSY  <= 1'b1;
            ENW   <= 1'b1;
            WRA   <= rx;
            DSEL  <= DSEL_G;
            DONE  <= 1'b1;
          end else begin
            state <= S_IDLE;
            if (!is_illegal) ICOUNT <= ICOUNT + 8'd1;
          end
        end
        // Counting on leaving the DONE cycle lets a reset in T1/T2 suppress the increment.
        S_T2: begin
          state  <= S_IDLE;
          ICOUNT <= ICOUNT + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_controller.sv
// tb/tb_rf_controller.sv - scoreboard bench for rf_controller
module tb_rf_controller;

  logic       CLKb = 1'b0;
  logic       RSTb;
  logic       EXEC;
  logic [9:0] INSTR;
  logic       ENW, ENR0, ALU_OP, BSEL, GIN, BUSY, DONE, ERR;
  logic [2:0] WRA, RDA0, RDA1;
  logic [1:0] DSEL;
  logic [7:0] ICOUNT;

  rf_controller dut (
    .CLKb(CLKb), .RSTb(RSTb), .EXEC(EXEC), .INSTR(INSTR),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .RDA1(RDA1),
    .DSEL(DSEL), .ALU_OP(ALU_OP), .BSEL(BSEL), .GIN(GIN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ICOUNT(ICOUNT)
  );

  always #5 CLKb = ~CLKb;

  typedef struct {
    string       name;
    logic [18:0] outs;
    logic [7:0]  icnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  icount_m;
  logic [18:0] obs;

  assign obs = {ENW, WRA, ENR0, RDA0, RDA1, DSEL, ALU_OP, BSEL, GIN, BUSY, DONE, ERR};

  function automatic logic [18:0] model_t1(input logic [9:0] i);
    logic [3:0] op;
    logic [2:0] rx, ry;
    logic enw, enr0, alu_op, bsel, gin, done, err;
    logic [2:0] wra, rda0, rda1;
    logic [1:0] dsel;
    op = i[9:6]; rx = i[5:3]; ry = i[2:0];
    {enw, enr0, alu_op, bsel, gin, done, err} = '0;
    wra = 0; rda0 = 0; rda1 = 0; dsel = 0;
    case (op)
      4'd0: begin enw = 1; wra = rx; dsel = 2'b00; done = 1; end
      4'd1: begin enr0 = 1; rda0 = ry; enw = 1; wra = rx; dsel = 2'b01; done = 1; end
      4'd2, 4'd3, 4'd4, 4'd5: begin
        enr0 = 1; rda0 = rx; rda1 = ry; gin = 1;
        alu_op = (op == 4'd3 || op == 4'd5);
        bsel = (op == 4'd4 || op == 4'd5);
      end
      default: begin done = 1; err = 1; end
    endcase
    return {enw, wra, enr0, rda0, rda1, dsel, alu_op, bsel, gin, 1'b1, done, err};
  endfunction

  function automatic logic [18:0] model_t2(input logic [9:0] i);
    logic [2:0] rx;
    rx = i[5:3];
    return {1'b1, rx, 1'b0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic push_instr(input logic [9:0] i, input string name);
    logic [3:0] op;
    op = i[9:6];
    EXEC = 1'b1;
    INSTR = i;
    exp_q.push_back('{name, model_t1(i), icount_m});
    if (op >= 4'd2 && op <= 4'd5) exp_q.push_back('{name, model_t2(i), icount_m});
    if (op <= 4'd5) icount_m = icount_m + 8'd1;
    exp_q.push_back('{name, 19'd0, icount_m});
  endtask

  task automatic test_reset();
    RSTb = 1'b0; EXEC = 1'b1; INSTR = 10'b0000_010_000;
    repeat (2) begin
      @(posedge CLKb); #1;
      tests++;
      if ({obs, ICOUNT} !== 27'd0) begin
        fails++;
        $display("FAIL reset_outputs: got %h/%0d expected 0/0", obs, ICOUNT);
      end
    end
    RSTb = 1'b1; EXEC = 1'b0; icount_m = 8'd0;
    @(posedge CLKb); #1;
    tests++;
    if ({obs, ICOUNT} !== 27'd0) begin
      fails++;
      $display("FAIL reset_idle: got %h/%0d expected 0/0", obs, ICOUNT);
    end
  endtask

  task automatic test_single();
    logic [9:0] tbl[4];
    string      nm[4];
    tbl = '{10'b0000_010_000, 10'b0010_011_101, 10'b0101_001_111, 10'b1111_000_000};
    nm  = '{"load_r2", "add_r3_r5", "subi_r1_7", "illegal_1111"};
    for (int k = 0; k < 4; k++) begin
      push_instr(tbl[k], nm[k]);
      while (exp_q.size() > 0) begin
        @(posedge CLKb); #1;
        EXEC = 1'b0; INSTR = 10'($urandom);
        e = exp_q.pop_front();
        tests++;
        if ({obs, ICOUNT} !== {e.outs, e.icnt}) begin
          fails++;
          $display("FAIL %s: got outs=%h icount=%0d expected outs=%h icount=%0d",
                   e.name, obs, ICOUNT, e.outs, e.icnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] i;
    logic [2:0] rx;
    for (int k = 0; k < 24; k++) begin
      rx = 3'($urandom);
      if (k == 0)      i = 10'b0001_000_000;
      else if (k == 1) i = 10'b0010_000_000;
      else             i = {4'($urandom_range(0, 7)), rx, (k % 3 == 0) ? rx : 3'($urandom)};
      push_instr(i, "back_to_back");
      while (exp_q.size() > 0) begin
        @(posedge CLKb); #1;
        EXEC = 1'b0; INSTR = 10'($urandom);
        e = exp_q.pop_front();
        tests++;
        if ({obs, ICOUNT} !== {e.outs, e.icnt}) begin
          fails++;
          $display("FAIL %s instr=%b: got outs=%h icount=%0d expected outs=%h icount=%0d",
                   e.name, i, obs, ICOUNT, e.outs, e.icnt);
        end
      end
    end
  endtask

  task automatic test_abort();
    EXEC = 1'b1; INSTR = 10'b0010_011_101;
    @(posedge CLKb); #1;
    EXEC = 1'b0;
    tests++;
    if (obs !== model_t1(10'b0010_011_101)) begin
      fails++;
      $display("FAIL abort_t1: got %h expected %h", obs, model_t1(10'b0010_011_101));
    end
    RSTb = 1'b0;
    icount_m = 8'd0;
    @(posedge CLKb); #1;
    RSTb = 1'b1;
    tests++;
    if ({obs, ICOUNT} !== 27'd0) begin
      fails++;
      $display("FAIL abort_reset_cycle: got %h/%0d expected 0/0", obs, ICOUNT);
    end
    @(posedge CLKb); #1;
    tests++;
    if ({obs, ICOUNT} !== 27'd0) begin
      fails++;
      $display("FAIL abort_after_release: got %h/%0d expected 0/0", obs, ICOUNT);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] mv;
    for (int k = 0; k < 256; k++) begin
      mv = {4'b0001, 3'(k), 3'(k >> 3)};
      EXEC = 1'b1; INSTR = mv;
      exp_q.push_back('{"wrap_mov_t1", model_t1(mv), icount_m});
      icount_m = icount_m + 8'd1;
      exp_q.push_back('{"wrap_idle", 19'd0, icount_m});
      while (exp_q.size() > 0) begin
        @(posedge CLKb); #1;
        INSTR = {4'b1111, 6'($urandom)};
        e = exp_q.pop_front();
        tests++;
        if ({obs, ICOUNT} !== {e.outs, e.icnt}) begin
          fails++;
          $display("FAIL %s k=%0d: got outs=%h icount=%0d expected outs=%h icount=%0d",
                   e.name, k, obs, ICOUNT, e.outs, e.icnt);
        end
      end
    end
    EXEC = 1'b0;
    tests++;
    if (ICOUNT !== 8'd0) begin
      fails++;
      $display("FAIL icount_wrap: got %0d expected 0", ICOUNT);
    end
  endtask

  initial begin
    RSTb = 1'b0; EXEC = 1'b0; INSTR = '0; icount_m = 8'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
